// File: rtl/top_password_oneshot.sv
// Four-digit password lock. Each switch rise is synchronized and turned into a single pulse.
// A valid one-hot pulse is taken as a key and drives the entry FSM and the 7-segment displays.
module top_password_oneshot #(
  parameter int unsigned P0 = 3,
  parameter int unsigned P1 = 7,
  parameter int unsigned P2 = 1,
  parameter int unsigned P3 = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] switches,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic       led_out
);

  typedef enum logic [2:0] {
    S_E0     = 3'd0,
    S_E1     = 3'd1,
    S_E2     = 3'd2,
    S_E3     = 3'd3,
    S_UNLOCK = 3'd4,
    S_ERROR  = 3'd5
  } state_t;

  localparam logic [3:0] LP_P0 = 4'(P0);
  localparam logic [3:0] LP_P1 = 4'(P1);
  localparam logic [3:0] LP_P2 = 4'(P2);
  localparam logic [3:0] LP_P3 = 4'(P3);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_L     = 7'b1000111;
  localparam logic [6:0] SEG_U     = 7'b1000001;
  localparam logic [6:0] SEG_E     = 7'b0000110;

  // Active-low {g,f,e,d,c,b,a} pattern for a decimal digit.
  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  logic [9:0] r_s1;
  logic [9:0] r_s2;
  logic [9:0] r_prev;
  logic [9:0] w_pulse;
  logic [9:0] w_pulse_dec;
  logic       w_key_valid;
  logic [3:0] w_key_digit;

  state_t     r_state;
  logic [3:0] r_digit0;
  logic [3:0] r_digit1;
  logic [3:0] r_digit2;
  logic [3:0] r_digit3;
  logic [3:0] r_slot_valid;
  logic       r_mismatch;

  // Two-flop synchronizer followed by the previous-value register for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1   <= 10'd0;
      r_s2   <= 10'd0;
      r_prev <= 10'd0;
    end else begin
      r_s1   <= switches;
      r_s2   <= r_s1;
      r_prev <= r_s2;
    end
  end

  assign w_pulse     = r_s2 & ~r_prev;
  assign w_pulse_dec = w_pulse - 10'd1;
  // Clearing the lowest set bit leaves zero only when exactly one bit was set.
  assign w_key_valid = (w_pulse != 10'd0) && ((w_pulse & w_pulse_dec) == 10'd0);

  // Index of the (single) pulsing switch; meaningless unless w_key_valid.
  always_comb begin
    w_key_digit = 4'd0;
    for (int i = 0; i < 10; i++) begin
      w_key_digit = w_key_digit | (w_pulse[i] ? 4'(i) : 4'd0);
    end
  end

  // Entry FSM with digit slots and the sticky mismatch flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_E0;
      r_digit0     <= 4'd0;
      r_digit1     <= 4'd0;
      r_digit2     <= 4'd0;
      r_digit3     <= 4'd0;
      r_slot_valid <= 4'b0000;
      r_mismatch   <= 1'b0;
    end else if (w_key_valid) begin
      case (r_state)
        S_E0: begin
          r_digit0     <= w_key_digit;
          r_slot_valid <= 4'b0001;
          r_mismatch   <= (w_key_digit != LP_P0);
          r_state      <= S_E1;
        end
        S_E1: begin
          r_digit1        <= w_key_digit;
          r_slot_valid[1] <= 1'b1;
          r_mismatch      <= r_mismatch | (w_key_digit != LP_P1);
          r_state         <= S_E2;
        end
        S_E2: begin
          r_digit2        <= w_key_digit;
          r_slot_valid[2] <= 1'b1;
          r_mismatch      <= r_mismatch | (w_key_digit != LP_P2);
          r_state         <= S_E3;
        end
        S_E3: begin
          r_digit3        <= w_key_digit;
          r_slot_valid[3] <= 1'b1;
          r_mismatch      <= r_mismatch | (w_key_digit != LP_P3);
          r_state         <= (r_mismatch || (w_key_digit != LP_P3)) ? S_ERROR : S_UNLOCK;
        end
        S_UNLOCK, S_ERROR: begin
          // A key after a finished attempt starts a fresh one with this key as digit 1.
          r_digit0     <= w_key_digit;
          r_digit1     <= 4'd0;
          r_digit2     <= 4'd0;
          r_digit3     <= 4'd0;
          r_slot_valid <= 4'b0001;
          r_mismatch   <= (w_key_digit != LP_P0);
          r_state      <= S_E1;
        end
        default: begin
          r_digit0     <= 4'd0;
          r_digit1     <= 4'd0;
          r_digit2     <= 4'd0;
          r_digit3     <= 4'd0;
          r_slot_valid <= 4'b0000;
          r_mismatch   <= 1'b0;
          r_state      <= S_E0;
        end
      endcase
    end else begin
      r_state <= r_state;
    end
  end

  // Display and LED decode from the registered state.
  always_comb begin
    HEX3    = r_slot_valid[0] ? seg_digit(r_digit0) : SEG_BLANK;
    HEX2    = r_slot_valid[1] ? seg_digit(r_digit1) : SEG_BLANK;
    HEX1    = r_slot_valid[2] ? seg_digit(r_digit2) : SEG_BLANK;
    HEX0    = r_slot_valid[3] ? seg_digit(r_digit3) : SEG_BLANK;
    led_out = 1'b0;
    case (r_state)
      S_E0, S_E1, S_E2, S_E3: HEX4 = SEG_L;
      S_UNLOCK: begin
        HEX4    = SEG_U;
        led_out = 1'b1;
      end
      S_ERROR:  HEX4 = SEG_E;
      default:  HEX4 = SEG_L;
    endcase
  end

endmodule

// File: tb/tb_top_password_oneshot.sv
// Self-checking bench for top_password_oneshot: table of key presses plus hand-written
// sequences for latency, overlapping switches and reset corners, checked via a scoreboard.
module tb_top_password_oneshot;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] switches;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4;
  logic       led_out;

  always #10 clk = ~clk;

  top_password_oneshot dut (
    .clk      (clk),
    .rst      (rst),
    .switches (switches),
    .HEX0     (HEX0),
    .HEX1     (HEX1),
    .HEX2     (HEX2),
    .HEX3     (HEX3),
    .HEX4     (HEX4),
    .led_out  (led_out)
  );

  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] D0 = 7'b1000000, D1 = 7'b1111001, D2 = 7'b0100100, D3 = 7'b0110000;
  localparam logic [6:0] D4 = 7'b0011001, D5 = 7'b0010010, D6 = 7'b0000010, D7 = 7'b1111000;
  localparam logic [6:0] D8 = 7'b0000000, D9 = 7'b0010000;
  localparam logic [6:0] GL = 7'b1000111, GU = 7'b1000001, GE = 7'b0000110;

  typedef struct {
    string       name;
    logic [35:0] val;
  } exp_t;

  typedef struct {
    string      name;
    logic [9:0] sw;
    int         hold;
    logic [6:0] h3, h2, h1, h0, h4;
    logic       led;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[13];
  int   checks = 0;
  int   errors = 0;

  task automatic push_exp(input string nm, input logic [6:0] h3, input logic [6:0] h2,
                          input logic [6:0] h1, input logic [6:0] h0, input logic [6:0] h4,
                          input logic led);
    exp_t e;
    e.name = nm;
    e.val  = {h3, h2, h1, h0, h4, led};
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t        e;
    logic [35:0] act;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: no expected entry queued");
    end else begin
      e   = sb.pop_front();
      act = {HEX3, HEX2, HEX1, HEX0, HEX4, led_out};
      if (act !== e.val) begin
        errors++;
        $display("FAIL %s: actual HEX3..HEX0,HEX4,led=%b_%b_%b_%b_%b_%b required %b_%b_%b_%b_%b_%b",
                 e.name, act[35:29], act[28:22], act[21:15], act[14:8], act[7:1], act[0],
                 e.val[35:29], e.val[28:22], e.val[21:15], e.val[14:8], e.val[7:1], e.val[0]);
      end
    end
  endtask

  // Raise a pattern at a falling edge, hold it, drop it, then let the pipeline settle.
  task automatic press(input logic [9:0] pat, input int hold);
    @(negedge clk);
    switches = pat;
    repeat (hold) @(negedge clk);
    switches = 10'd0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    tbl[0]  = '{"t0_key3",       10'b0000001000, 1,  D3, BL, BL, BL, GL, 1'b0};
    tbl[1]  = '{"t1_key7",       10'b0010000000, 1,  D3, D7, BL, BL, GL, 1'b0};
    tbl[2]  = '{"t2_key1",       10'b0000000010, 1,  D3, D7, D1, BL, GL, 1'b0};
    tbl[3]  = '{"t3_key5_unlock",10'b0000100000, 1,  D3, D7, D1, D5, GU, 1'b1};
    tbl[4]  = '{"t4_key3_relock",10'b0000001000, 1,  D3, BL, BL, BL, GL, 1'b0};
    tbl[5]  = '{"t5_key7",       10'b0010000000, 2,  D3, D7, BL, BL, GL, 1'b0};
    tbl[6]  = '{"t6_key1",       10'b0000000010, 1,  D3, D7, D1, BL, GL, 1'b0};
    tbl[7]  = '{"t7_key4_error", 10'b0000010000, 1,  D3, D7, D1, D4, GE, 1'b0};
    tbl[8]  = '{"t8_multi_2_6",  10'b0001000100, 2,  D3, D7, D1, D4, GE, 1'b0};
    tbl[9]  = '{"t9_hold3_10cyc",10'b0000001000, 10, D3, BL, BL, BL, GL, 1'b0};
    tbl[10] = '{"t10_key9",      10'b1000000000, 1,  D3, D9, BL, BL, GL, 1'b0};
    tbl[11] = '{"t11_key8",      10'b0100000000, 1,  D3, D9, D8, BL, GL, 1'b0};
    tbl[12] = '{"t12_key2_error",10'b0000000100, 1,  D3, D9, D8, D2, GE, 1'b0};

    rst      = 1'b0;
    switches = 10'd0;
    repeat (2) @(negedge clk);
    push_exp("reset_values", BL, BL, BL, BL, GL, 1'b0);
    pop_check();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    push_exp("after_release", BL, BL, BL, BL, GL, 1'b0);
    pop_check();

    for (int i = 0; i < 13; i++) begin
      push_exp(tbl[i].name, tbl[i].h3, tbl[i].h2, tbl[i].h1, tbl[i].h0, tbl[i].h4, tbl[i].led);
      press(tbl[i].sw, tbl[i].hold);
      pop_check();
    end

    // From ERROR: switch 3 held while switch 7 rises -> both accepted as separate keys.
    @(negedge clk);
    switches = 10'b0000001000;
    repeat (3) @(negedge clk);
    switches = 10'b0010001000;
    repeat (3) @(negedge clk);
    switches = 10'd0;
    repeat (4) @(negedge clk);
    push_exp("overlap_3_then_7", D3, D7, BL, BL, GL, 1'b0);
    pop_check();

    // Asynchronous reset mid-entry takes effect before the next clock edge.
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    push_exp("reset_mid_entry", BL, BL, BL, BL, GL, 1'b0);
    pop_check();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Latency: outputs change at the second edge after the switch is first sampled.
    press(10'b0000001000, 1);
    press(10'b0010000000, 1);
    press(10'b0000000010, 1);
    @(negedge clk);
    switches = 10'b0000100000;
    @(posedge clk);
    @(negedge clk);
    switches = 10'd0;
    @(posedge clk);
    #1;
    push_exp("latency_edge_n1", D3, D7, D1, BL, GL, 1'b0);
    pop_check();
    @(posedge clk);
    #1;
    push_exp("latency_edge_n2", D3, D7, D1, D5, GU, 1'b1);
    pop_check();

    // Switch held high across reset release is accepted as a key afterwards.
    @(negedge clk);
    rst      = 1'b0;
    switches = 10'b0000001000;
    #1;
    push_exp("reset_from_unlock", BL, BL, BL, BL, GL, 1'b0);
    pop_check();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    switches = 10'd0;
    repeat (3) @(negedge clk);
    push_exp("held_across_reset", D3, BL, BL, BL, GL, 1'b0);
    pop_check();

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: actual %0d entries required 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
